wb_commit_order: RTL
====================

Name: wb_commit_order

Overview:
- Parametrised successor to the dual-issue writeback ordering logic.
- Accepts up to LANES writeback results per cycle from the issue slots; lane 0 is the oldest in program order.
- Squashes same-cycle WAW collisions and drops writes to register 0.
- Buffers surviving writes in an in-order circular FIFO and drains up to WPORTS writes per cycle to the register file, so a narrow register file can sit behind a wide issue stage.

Parameters:
LANES, 2, number of writeback lanes presented per cycle (1..4)
WPORTS, 1, register-file write ports driven per cycle (1..LANES)
DEPTH, 4, FIFO entries, power of two, DEPTH >= LANES
AWIDTH, `AWIDTH, register address width
DWIDTH, `DWIDTH, data width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
co_i_flush  input  1  synchronous flush of all buffered writes
co_i_valid  input  LANES  lane i carries a result
co_i_we  input  LANES  lane i writes the register file
co_i_addr_rd  input  LANES*AWIDTH  destination of lane i, lane i at bits [i*AWIDTH +: AWIDTH]
co_i_data  input  LANES*DWIDTH  result of lane i
co_o_ready  output  1  a full group can be accepted this cycle
co_o_wb_en  output  WPORTS  write enable per port
co_o_wb_addr  output  WPORTS*AWIDTH  write address per port
co_o_wb_data  output  WPORTS*DWIDTH  write data per port
co_o_count  output  clog2(DEPTH+1)  buffered entries
co_o_empty  output  1  count == 0

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers and count cleared; co_o_wb_en, co_o_wb_addr, co_o_wb_data = 0; co_o_empty = 1.
- co_o_ready = ((DEPTH - count) >= LANES), combinational from the registered count. It is deliberately conservative: it ignores the pop in the same cycle.
- Accept: a group is accepted when co_o_ready = 1 and any co_i_valid bit is set. Inputs with co_o_ready = 0 are ignored; the producer must hold them.
- Lane i is live when co_i_valid[i] & co_i_we[i] & (addr_rd[i] != 0).
- Same-group WAW: a live lane i is squashed if any younger live lane j > i has an equal addr_rd.
- Surviving lanes are pushed contiguously at the tail, in ascending lane order.
- Pointers wrap modulo DEPTH.
- Drain: each cycle, n = min(count, WPORTS) entries are popped from the head. Port k is driven with the k-th oldest entry, and co_o_wb_* are registered.
  - An entry pushed at edge t appears on the ports at edge t+1 at the earliest (one-cycle latency).
  - Ports k >= n have en = 0 and addr/data = 0.
- Same-drain WAW: if two ports in one drain cycle carry equal addresses, the older port's en is cleared. Only the youngest write reaches the register file.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped.
- Group with zero survivors (all squashed or register 0): accepted; count unchanged except for the pop.
- co_i_flush has priority over everything, on the next edge:
  - Pointers and count are cleared and co_o_wb_en = 0.
  - An input group presented in the same cycle is dropped.
  - A drain scheduled in the same cycle is suppressed.
- Reset asserted mid-drain: outputs clear immediately (asynchronous), and buffered entries are lost.
- Ordering guarantee: the register-file write sequence equals program order after WAW squashing, and no entry is lost or duplicated.

Test Plan:
- Single write (LANES=2, WPORTS=1): lane0 {we=1, rd=5, data=0xAAAA0001}, lane1 invalid -> next cycle en=1, addr=5, data=0xAAAA0001; count returns to 0; empty=1.
- Same-group WAW: lane0 {rd=7, 0x11}, lane1 {rd=7, 0x22} -> only one entry pushed (count=1); port writes rd=7 with 0x22; 0x11 never appears.
- Register 0 and ordering: lane0 {rd=0, 0x33}, lane1 {rd=3, 0x44}, next group lane0 {rd=4, 0x55}, lane1 {rd=6, 0x66} -> writes rd3=0x44, rd4=0x55, rd6=0x66 on consecutive cycles; no write to rd0.
- Backpressure and wrap: DEPTH=4, full groups every cycle -> ready drops to 0 once count > 2; with ready low, inputs held and ignored; after 10 groups, 20 writes emerge in order with pointers wrapped at least twice.
- WPORTS=2 same-drain WAW: two buffered entries {rd=9, 0x1}, {rd=9, 0x2} drained together -> port0 en=0, port1 en=1, addr=9, data=0x2.
- Flush and reset: count=3, then flush with a valid group present -> next cycle count=0, en=0, group dropped. Pulse rst_n low mid-drain -> en=0 immediately and empty=1.

Source files
------------

// File: rtl/wb_commit_order.sv
// rtl/wb_commit_order.sv - in-order writeback commit buffer with WAW squashing and narrow register-file drain
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module wb_commit_order #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4,
  parameter int AWIDTH = `AWIDTH,
  parameter int DWIDTH = `DWIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         co_i_flush,
  input  logic [LANES-1:0]             co_i_valid,
  input  logic [LANES-1:0]             co_i_we,
  input  logic [LANES*AWIDTH-1:0]      co_i_addr_rd,
  input  logic [LANES*DWIDTH-1:0]      co_i_data,
  output logic                         co_o_ready,
  output logic [WPORTS-1:0]            co_o_wb_en,
  output logic [WPORTS*AWIDTH-1:0]     co_o_wb_addr,
  output logic [WPORTS*DWIDTH-1:0]     co_o_wb_data,
  output logic [$clog2(DEPTH+1)-1:0]   co_o_count,
  output logic                         co_o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [AWIDTH-1:0]        r_mem_addr [DEPTH];
  logic [DWIDTH-1:0]        r_mem_data [DEPTH];
  logic [PW-1:0]            r_head, r_tail;
  logic [CW-1:0]            r_count;
  logic [WPORTS-1:0]        r_wb_en;
  logic [WPORTS*AWIDTH-1:0] r_wb_addr;
  logic [WPORTS*DWIDTH-1:0] r_wb_data;

  logic [LANES-1:0]         w_live, w_surv;
  logic [PW-1:0]            w_waddr [LANES];
  logic [PW-1:0]            w_ridx [WPORTS];
  logic [WPORTS-1:0]        w_take;
  logic [WPORTS-1:0]        w_nx_en;
  logic [WPORTS*AWIDTH-1:0] w_nx_addr;
  logic [WPORTS*DWIDTH-1:0] w_nx_data;
  logic [CW-1:0]            w_npush, w_npop;
  logic [PW-1:0]            w_head_next, w_tail_next;
  logic                     w_accept;
  int                       w_push_n;

  assign co_o_ready   = (DEPTH - int'(r_count)) >= LANES;
  assign w_accept     = co_o_ready & (|co_i_valid) & ~co_i_flush;
  assign co_o_count   = r_count;
  assign co_o_empty   = (r_count == '0);
  assign co_o_wb_en   = r_wb_en;
  assign co_o_wb_addr = r_wb_addr;
  assign co_o_wb_data = r_wb_data;

  // A live lane survives only if no younger live lane in the group targets the same register.
  always_comb begin
    w_live = '0;
    w_surv = '0;
    for (int i = 0; i < LANES; i++)
      w_live[i] = co_i_valid[i] & co_i_we[i] & (co_i_addr_rd[i*AWIDTH +: AWIDTH] != '0);
    for (int i = 0; i < LANES; i++) begin
      w_surv[i] = w_live[i];
      for (int j = 0; j < LANES; j++)
        if (j > i && w_live[j] &&
            co_i_addr_rd[j*AWIDTH +: AWIDTH] == co_i_addr_rd[i*AWIDTH +: AWIDTH])
          w_surv[i] = 1'b0;
    end
  end

  always_comb begin
    w_push_n = 0;
    for (int i = 0; i < LANES; i++) begin
      w_waddr[i] = PW'((int'(r_tail) + w_push_n) % DEPTH);
      if (w_surv[i]) w_push_n = w_push_n + 1;
    end
    w_npush     = w_accept ? CW'(w_push_n) : '0;
    w_npop      = co_i_flush ? '0 : ((32'(r_count) < WPORTS) ? r_count : CW'(WPORTS));
    w_tail_next = PW'((int'(r_tail) + int'(w_npush)) % DEPTH);
    w_head_next = PW'((int'(r_head) + int'(w_npop)) % DEPTH);
  end

  // Older port is disabled when a younger port in the same drain hits the same register.
  always_comb begin
    w_take    = '0;
    w_nx_en   = '0;
    w_nx_addr = '0;
    w_nx_data = '0;
    for (int k = 0; k < WPORTS; k++) begin
      w_ridx[k] = PW'((int'(r_head) + k) % DEPTH);
      w_take[k] = (k < int'(w_npop));
      if (w_take[k]) begin
        w_nx_addr[k*AWIDTH +: AWIDTH] = r_mem_addr[w_ridx[k]];
        w_nx_data[k*DWIDTH +: DWIDTH] = r_mem_data[w_ridx[k]];
      end
    end
    for (int k = 0; k < WPORTS; k++) begin
      w_nx_en[k] = w_take[k];
      for (int m = 0; m < WPORTS; m++)
        if (m > k && w_take[m] && w_take[k] &&
            r_mem_addr[w_ridx[m]] == r_mem_addr[w_ridx[k]])
          w_nx_en[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (w_accept && w_surv[i]) begin
        r_mem_addr[w_waddr[i]] <= co_i_addr_rd[i*AWIDTH +: AWIDTH];
        r_mem_data[w_waddr[i]] <= co_i_data[i*DWIDTH +: DWIDTH];
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wb_en   <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (co_i_flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wb_en   <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_head    <= w_head_next;
      r_tail    <= w_tail_next;
      r_count   <= r_count + w_npush - w_npop;
      r_wb_en   <= w_nx_en;
      r_wb_addr <= w_nx_addr;
      r_wb_data <= w_nx_data;
    end
  end
endmodule
